// File: rtl/shift_reg_multi_if.sv
// Handshake/data bundle for shift_reg_multi.
// The controller drives it through the master modport and the register through slave.
interface shift_reg_multi_if #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
);
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] amount;
    logic             rot;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output load, data_in, start, dir, amount, rot, ser_in,
        input  q, ser_out, busy, done
    );

    modport slave (
        input  load, data_in, start, dir, amount, rot, ser_in,
        output q, ser_out, busy, done
    );
endinterface

// File: rtl/shift_reg_multi.sv
// Multi-position shift register with parallel load, serial in/out and a
// busy/done handshake. One position is shifted per clock.
// Optional feature macro: ROTATE_EN (rot=1 turns the shift into a circular rotate).
module shift_reg_multi #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input logic            clk,
    input logic            clear,
    shift_reg_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ser_q, ser_d;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             out_bit;
    logic             fill;

`ifdef ROTATE_EN
    logic             rot_q;
`else
    // rot has no effect in this build
    logic             unused_rot;
    assign unused_rot = bus.rot;
`endif

    // Next register value for a single one-position shift
    always_comb begin
        out_bit = dir_q ? q_q[0] : q_q[WIDTH-1];
        fill    = bus.ser_in;
`ifdef ROTATE_EN
        if (rot_q) fill = out_bit;
`endif
        q_d   = dir_q ? {fill, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], fill};
        ser_d = out_bit;
    end

    // Control FSM and datapath registers; clear aborts any operation
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            q_q     <= '0;
            ser_q   <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
`ifdef ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        q_q <= bus.data_in;
                    end else if (bus.start) begin
                        if (bus.amount != '0) begin
                            dir_q   <= bus.dir;
`ifdef ROTATE_EN
                            rot_q   <= bus.rot;
`endif
                            cnt_q   <= bus.amount;
                            state_q <= SHIFT;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    q_q   <= q_d;
                    ser_q <= ser_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.q       = q_q;
    assign bus.ser_out = ser_q;
    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = (state_q == DONE);
endmodule
